// File: rtl/sqrt_pkg.sv
// ---------------------------------------------------------------------------
// sqrt_pkg
// Shared definitions for the iterative integer square-root unit:
//   - state_t  : controller state encoding (IDLE / CALC / DONE)
//   - width_ok : operand-width legality check used at elaboration
// No ports (package).
// ---------------------------------------------------------------------------
package sqrt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    // The recurrence consumes two operand bits per step, so the operand
    // width has to be even, and at least two steps are needed.
    function automatic bit width_ok(input int w);
        return (w >= 4) && ((w % 2) == 0);
    endfunction

endpackage

// File: rtl/sqrt_step.sv
// ---------------------------------------------------------------------------
// sqrt_step
// One restoring digit step of the integer square root. Purely
// combinational, so it can be reused unrolled in a pipelined variant.
//   q      : partial root so far (RW bits)
//   r      : partial remainder so far (RW+2 bits)
//   pair   : next two operand bits, MSB first
//   q_next : partial root with the new digit appended
//   r_next : updated partial remainder
// ---------------------------------------------------------------------------
module sqrt_step #(
    parameter int RW = 8
) (
    input  logic [RW-1:0] q,
    input  logic [RW+1:0] r,
    input  logic [1:0]    pair,
    output logic [RW-1:0] q_next,
    output logic [RW+1:0] r_next
);

    // The shifted remainder and trial value are formed two bits wider than
    // the stored remainder so that every input bit takes part in the
    // compare. The extra upper bits are always zero in a legal sequence,
    // so truncating the result back to RW+2 bits loses nothing.
    localparam int EW = RW + 4;

    logic [EW-1:0] r_sh;
    logic [EW-1:0] trial;
    logic          ge;

    assign r_sh  = {r, pair};
    assign trial = {2'b00, q, 2'b01};
    assign ge    = (r_sh >= trial);

    assign r_next = ge ? (RW+2)'(r_sh - trial) : (RW+2)'(r_sh);
    // Shift the new digit in; the bit falling off the top is always zero
    // because q only ever holds as many digits as steps completed.
    assign q_next = RW'({q, ge});

endmodule

// File: rtl/sqrt_iter.sv
// ---------------------------------------------------------------------------
// sqrt_iter
// Iterative unsigned integer square root: one root bit per clock.
// Produces root = floor(sqrt(x)) and rem = x - root^2 for a W-bit operand.
//   clk_i       : clock, rising edge
//   rst_ni      : asynchronous active-low reset
//   in_valid_i  : operand valid
//   in_ready_o  : unit idle and able to take an operand
//   x_i         : W-bit unsigned operand
//   out_valid_o : result valid (held until consumed)
//   out_ready_i : consumer takes the result
//   root_o      : RW-bit root
//   rem_o       : RW+1-bit remainder, never above 2*root
//   busy_o      : computing or holding a result
// Accept edge to out_valid_o rising is RW clock edges; the unit returns to
// IDLE on the result handshake and accepts again one cycle later.
// ---------------------------------------------------------------------------
module sqrt_iter
    import sqrt_pkg::*;
#(
    parameter  int W  = 16,
    localparam int RW = W / 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [W-1:0]  x_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [RW-1:0] root_o,
    output logic [RW:0]   rem_o,
    output logic          busy_o
);

    generate
        if (!width_ok(W)) begin : g_bad_width
            $error("sqrt_iter: W must be even and at least 4");
        end
    endgenerate

    localparam int CW = (RW > 1) ? $clog2(RW) : 1;

    state_t          state_q;
    state_t          state_d;
    logic [W-1:0]    x_q;
    logic [RW-1:0]   q_q;
    logic [RW+1:0]   r_q;
    logic [CW-1:0]   cnt_q;
    logic [RW-1:0]   q_nxt;
    logic [RW+1:0]   r_nxt;

    sqrt_step #(
        .RW (RW)
    ) u_step (
        .q      (q_q),
        .r      (r_q),
        .pair   (x_q[W-1:W-2]),
        .q_next (q_nxt),
        .r_next (r_nxt)
    );

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid_i)    state_d = CALC;
            CALC:    if (cnt_q == '0)   state_d = DONE;
            DONE:    if (out_ready_i)   state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // Outputs decoded from the state only
    always_comb begin
        in_ready_o  = (state_q == IDLE);
        out_valid_o = (state_q == DONE);
        busy_o      = (state_q == CALC) || (state_q == DONE);
    end

    // Datapath: operand shifter, partial root/remainder, step counter and
    // the result registers. The result registers are loaded from the last
    // step's combinational outputs so DONE is entered with them valid.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_q    <= '0;
            q_q    <= '0;
            r_q    <= '0;
            cnt_q  <= '0;
            root_o <= '0;
            rem_o  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        x_q   <= x_i;
                        q_q   <= '0;
                        r_q   <= '0;
                        cnt_q <= CW'(RW - 1);
                    end
                end
                CALC: begin
                    x_q <= {x_q[W-3:0], 2'b00};
                    q_q <= q_nxt;
                    r_q <= r_nxt;
                    if (cnt_q == '0) begin
                        root_o <= q_nxt;
                        // Final remainder is at most 2*root, which fits RW+1 bits.
                        rem_o  <= (RW+1)'(r_nxt);
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sqrt_iter.sv
// ---------------------------------------------------------------------------
// tb_sqrt_iter
// Self-checking bench for sqrt_iter: a W=16 instance driven with directed
// operands (latency, backpressure, back-to-back issue, asynchronous reset
// abort) and a W=8 instance swept over every operand. Expected results are
// queued at issue time and checked by per-instance monitors on handshake.
// ---------------------------------------------------------------------------
module tb_sqrt_iter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;

    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [15:0] x;
    logic [7:0]  root;
    logic [8:0]  rem;

    logic        v8, rdy8, ov8, or8, busy8;
    logic [7:0]  x8;
    logic [3:0]  root8;
    logic [4:0]  rem8;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int x;
        int root;
        int rem;
    } exp_t;

    exp_t sb16[$];
    exp_t sb8[$];

    always #5 clk = ~clk;

    sqrt_iter #(.W(16)) dut16 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .x_i         (x),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .root_o      (root),
        .rem_o       (rem),
        .busy_o      (busy)
    );

    sqrt_iter #(.W(8)) dut8 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (v8),
        .in_ready_o  (rdy8),
        .x_i         (x8),
        .out_valid_o (ov8),
        .out_ready_i (or8),
        .root_o      (root8),
        .rem_o       (rem8),
        .busy_o      (busy8)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int isqrt(input int v);
        int r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    // Monitors: pop and compare on every result handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin : mon16
            exp_t e;
            if (sb16.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL w16_unexpected: got result %0d/%0d, expected none", root, rem);
            end else begin
                e = sb16.pop_front();
                chk($sformatf("w16_root_x%0d", e.x), int'(root), e.root);
                chk($sformatf("w16_rem_x%0d", e.x), int'(rem), e.rem);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && ov8 && or8) begin : mon8
            exp_t e;
            if (sb8.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL w8_unexpected: got result %0d/%0d, expected none", root8, rem8);
            end else begin
                e = sb8.pop_front();
                chk($sformatf("w8_root_x%0d", e.x), int'(root8), e.root);
                chk($sformatf("w8_rem_x%0d", e.x), int'(rem8), e.rem);
                chk($sformatf("w8_sum_x%0d", e.x),
                    int'(root8) * int'(root8) + int'(rem8), e.x);
                chk($sformatf("w8_rembound_x%0d", e.x),
                    (int'(rem8) <= 2 * int'(root8)) ? 1 : 0, 1);
            end
        end
    end

    task automatic wait_ready16();
        bit ok = 1'b0;
        for (int k = 0; k < 64 && !ok; k++) begin
            if (in_ready) ok = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL w16_ready_timeout: in_ready got 0, expected 1");
        end
    endtask

    task automatic wait_ready8();
        bit ok = 1'b0;
        for (int k = 0; k < 64 && !ok; k++) begin
            if (rdy8) ok = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL w8_ready_timeout: in_ready got 0, expected 1");
        end
    endtask

    // Issue one operand and return the number of edges from accept to
    // out_valid rising (-1 if it never rises within the budget).
    task automatic issue16(input logic [15:0] xv, input int er, input int erem,
                           output int lat);
        wait_ready16();
        in_valid = 1'b1;
        x        = xv;
        sb16.push_back('{int'(xv), er, erem});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        bit seen;

        in_valid  = 1'b0;
        x         = '0;
        out_ready = 1'b1;
        v8        = 1'b0;
        x8        = '0;
        or8       = 1'b1;

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_root", int'(root), 0);
        chk("rst_rem", int'(rem), 0);
        chk("rst_w8_ready", int'(rdy8), 1);
        chk("rst_w8_busy", int'(busy8), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic results and latency
        issue16(16'd144, 12, 0, lat);
        chk("lat_144", lat, 8);
        issue16(16'd0, 0, 0, lat);
        chk("lat_0", lat, 8);
        issue16(16'd65535, 255, 510, lat);
        chk("lat_65535", lat, 8);

        // Backpressure: result held while out_ready is low
        wait_ready16();
        out_ready = 1'b0;
        issue16(16'd200, 14, 4, lat);
        chk("lat_200", lat, 8);
        in_valid = 1'b1;
        x        = 16'd9999;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_root", int'(root), 14);
            chk("hold_rem", int'(rem), 4);
            chk("hold_in_ready", int'(in_ready), 0);
            chk("hold_busy", int'(busy), 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_valid", int'(out_valid), 0);
        chk("release_in_ready", int'(in_ready), 1);
        chk("release_busy", int'(busy), 0);

        // Back-to-back with in_valid held high; x changes during CALC
        wait_ready16();
        in_valid = 1'b1;
        x        = 16'd49;
        sb16.push_back('{49, 7, 0});
        for (int e = 0; e <= 10; e++) begin
            @(posedge clk);
            #1;
            if (e == 0) x = 16'd123;
            if (e == 3) begin
                x = 16'd50;
                sb16.push_back('{50, 7, 1});
            end
            if (e == 8) chk("b2b_valid_e8", int'(out_valid), 1);
            if (e == 9) chk("b2b_ready_e9", int'(in_ready), 1);
            if (e == 10) begin
                chk("b2b_busy_e10", int'(busy), 1);
                in_valid = 1'b0;
            end
        end
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        chk("lat_b2b_50", lat, 8);

        // Asynchronous reset in the middle of CALC aborts the operation
        wait_ready16();
        in_valid = 1'b1;
        x        = 16'd1000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_in_ready", int'(in_ready), 1);
        chk("abort_valid", int'(out_valid), 0);
        chk("abort_root", int'(root), 0);
        chk("abort_rem", int'(rem), 0);
        #3 rst_n = 1'b1;
        issue16(16'd81, 9, 0, lat);
        chk("lat_81", lat, 8);
        repeat (3) @(posedge clk);
        #1;
        chk("sb16_drained", sb16.size(), 0);

        // W=8 exhaustive sweep against the reference model
        for (int v = 0; v < 256; v++) begin
            int rt;
            wait_ready8();
            rt = isqrt(v);
            v8 = 1'b1;
            x8 = 8'(v);
            sb8.push_back('{v, rt, v - rt * rt});
            @(posedge clk);
            #1;
            v8 = 1'b0;
        end
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            if (sb8.size() == 0) seen = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        chk("sb8_drained", sb8.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation got no completion, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
